// File: rtl/pwm_demod.sv
// PWM demodulator: recovers the duty cycle of an asynchronous PWM line whose
// frame is 2^PW clocks long. Each completed frame yields an 8-bit sample.
// The receiver hunts for a rising edge to fix the frame phase. It then tracks
// frames, counting phase errors and reporting lock after a run of clean frames.
module pwm_demod #(
  parameter int PW          = 8,
  parameter int LOCK_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       ain,
  output logic [7:0] sample,
  output logic       sample_valid,
  output logic       locked,
  output logic [7:0] phase_err_cnt
);

  localparam logic [PW-1:0] LAST_POS = {PW{1'b1}};
  localparam logic [3:0]    LOCK_N   = 4'(LOCK_FRAMES);
  localparam logic [PW:0]   SAT_MAX  = (PW+1)'(255);

  typedef enum logic {HUNT, TRACK} state_t;

  state_t        state_q, state_d;
  logic          meta_q, meta_d;
  logic          s_q, s_d;
  logic          sd_q, sd_d;
  logic [PW-1:0] frame_cnt_q, frame_cnt_d;
  logic [PW:0]   high_cnt_q, high_cnt_d;
  logic [3:0]    clean_cnt_q, clean_cnt_d;
  logic          locked_q, locked_d;
  logic [7:0]    sample_q, sample_d;
  logic          sample_valid_q, sample_valid_d;
  logic [7:0]    perr_q, perr_d;

  logic          rise;
  logic [PW:0]   frame_total;
  logic [PW:0]   frame_scaled;

  // Scale the frame's high count down to 8 bits, clamping the all-high frame.
  function automatic logic [7:0] sat8(input logic [PW:0] v);
    if (v > SAT_MAX) return 8'hFF;
    return v[7:0];
  endfunction

  // Next-state logic: synchronizer shift, HUNT/TRACK frame tracking, lock and
  // phase-error bookkeeping.
  always_comb begin
    meta_d         = ain;
    s_d            = meta_q;
    sd_d           = s_q;
    state_d        = state_q;
    frame_cnt_d    = frame_cnt_q;
    high_cnt_d     = high_cnt_q;
    clean_cnt_d    = clean_cnt_q;
    locked_d       = locked_q;
    sample_d       = sample_q;
    sample_valid_d = 1'b0;
    perr_d         = perr_q;

    rise         = s_q & ~sd_q;
    frame_total  = high_cnt_q + (PW+1)'(s_q);
    frame_scaled = frame_total >> (PW - 8);

    if (!en) begin
      state_d     = HUNT;
      frame_cnt_d = '0;
      high_cnt_d  = '0;
      clean_cnt_d = '0;
      locked_d    = 1'b0;
    end else begin
      case (state_q)
        HUNT: begin
          frame_cnt_d = '0;
          high_cnt_d  = '0;
          if (rise) begin
            state_d     = TRACK;
            frame_cnt_d = PW'(1);
            high_cnt_d  = (PW+1)'(1);
          end
        end
        TRACK: begin
          if (rise && (frame_cnt_q != '0)) begin
            // Edge out of phase: drop the partial frame and restart on it.
            frame_cnt_d = PW'(1);
            high_cnt_d  = (PW+1)'(1);
            clean_cnt_d = '0;
            locked_d    = 1'b0;
            if (perr_q != 8'hFF) perr_d = perr_q + 8'd1;
          end else if (frame_cnt_q == LAST_POS) begin
            sample_d       = sat8(frame_scaled);
            sample_valid_d = 1'b1;
            frame_cnt_d    = '0;
            high_cnt_d     = '0;
            if (clean_cnt_q < LOCK_N) clean_cnt_d = clean_cnt_q + 4'd1;
            if (clean_cnt_d == LOCK_N) locked_d = 1'b1;
          end else begin
            frame_cnt_d = frame_cnt_q + PW'(1);
            high_cnt_d  = frame_total;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // State register; reset clears everything including the synchronizer.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q         <= 1'b0;
      s_q            <= 1'b0;
      sd_q           <= 1'b0;
      state_q        <= HUNT;
      frame_cnt_q    <= '0;
      high_cnt_q     <= '0;
      clean_cnt_q    <= '0;
      locked_q       <= 1'b0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      perr_q         <= '0;
    end else begin
      meta_q         <= meta_d;
      s_q            <= s_d;
      sd_q           <= sd_d;
      state_q        <= state_d;
      frame_cnt_q    <= frame_cnt_d;
      high_cnt_q     <= high_cnt_d;
      clean_cnt_q    <= clean_cnt_d;
      locked_q       <= locked_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      perr_q         <= perr_d;
    end
  end

  assign sample        = sample_q;
  assign sample_valid  = sample_valid_q;
  assign locked        = locked_q;
  assign phase_err_cnt = perr_q;

endmodule

// File: tb/tb_pwm_demod.sv
// Bench for pwm_demod: a PW=8 and a PW=9 instance share one PWM line.
// A frame-level reference model predicts every output each cycle, and
// directed literal checks pin the key scenarios.
module tb_pwm_demod;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b1;
  logic       ain = 1'b0;
  logic [7:0] sample0, perr0, sample1, perr1;
  logic       valid0, locked0, valid1, locked1;

  always #5 clk = ~clk;

  pwm_demod #(.PW(8), .LOCK_FRAMES(4)) dut0 (
    .clk(clk), .rst(rst), .en(en), .ain(ain),
    .sample(sample0), .sample_valid(valid0), .locked(locked0), .phase_err_cnt(perr0));

  pwm_demod #(.PW(9), .LOCK_FRAMES(4)) dut1 (
    .clk(clk), .rst(rst), .en(en), .ain(ain),
    .sample(sample1), .sample_valid(valid1), .locked(locked1), .phase_err_cnt(perr1));

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  task automatic cmp(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the line delayed through three flops. Each receiver is
  // described by the length and high-count of the frame in progress.
  bit m_s1 = 0, m_s = 0, m_sd = 0;
  bit m_trk[2]    = '{0, 0};
  int m_len[2]    = '{0, 0};
  int m_sum[2]    = '{0, 0};
  int m_sample[2] = '{0, 0};
  bit m_valid[2]  = '{0, 0};
  bit m_locked[2] = '{0, 0};
  int m_perr[2]   = '{0, 0};
  int m_clean[2]  = '{0, 0};

  always @(posedge clk) begin
    bit rise;
    int per, total;
    rise = m_s & ~m_sd;
    if (rst) begin
      m_s1 = 0; m_s = 0; m_sd = 0;
      for (int k = 0; k < 2; k++) begin
        m_trk[k] = 0; m_len[k] = 0; m_sum[k] = 0; m_sample[k] = 0;
        m_valid[k] = 0; m_locked[k] = 0; m_perr[k] = 0; m_clean[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        per = (k == 0) ? 256 : 512;
        m_valid[k] = 0;
        if (!en) begin
          m_trk[k] = 0; m_len[k] = 0; m_sum[k] = 0;
          m_clean[k] = 0; m_locked[k] = 0;
        end else if (!m_trk[k]) begin
          if (rise) begin m_trk[k] = 1; m_len[k] = 1; m_sum[k] = 1; end
        end else if (rise && m_len[k] != 0) begin
          m_len[k] = 1; m_sum[k] = 1;
          m_perr[k] = (m_perr[k] < 255) ? m_perr[k] + 1 : 255;
          m_clean[k] = 0; m_locked[k] = 0;
        end else if (m_len[k] == per - 1) begin
          total = m_sum[k] + int'(m_s);
          total = total / (per / 256);
          m_sample[k] = (total > 255) ? 255 : total;
          m_valid[k] = 1;
          m_len[k] = 0; m_sum[k] = 0;
          m_clean[k] = (m_clean[k] < 4) ? m_clean[k] + 1 : 4;
          if (m_clean[k] == 4) m_locked[k] = 1;
        end else begin
          m_len[k] = m_len[k] + 1;
          m_sum[k] = m_sum[k] + int'(m_s);
        end
      end
      m_sd = m_s; m_s = m_s1; m_s1 = ain;
    end
  end

  // Per-cycle comparison against the model, plus strobe bookkeeping for dut0.
  int nstb0 = 0;
  int lock_strobe = 0;
  always @(negedge clk) begin
    if (chk_on) begin
      cmp("sample0", sample0, m_sample[0]);
      cmp("valid0", valid0, m_valid[0]);
      cmp("locked0", locked0, m_locked[0]);
      cmp("perr0", perr0, m_perr[0]);
      cmp("sample1", sample1, m_sample[1]);
      cmp("valid1", valid1, m_valid[1]);
      cmp("locked1", locked1, m_locked[1]);
      cmp("perr1", perr1, m_perr[1]);
    end
    if (rst) begin
      nstb0 = 0; lock_strobe = 0;
    end else begin
      if (valid0) nstb0++;
      if (locked0 && lock_strobe == 0) lock_strobe = nstb0;
    end
  end

  task automatic tick(input bit a);
    @(negedge clk);
    ain = a;
  endtask

  task automatic frame(input int high, input int per);
    for (int i = 0; i < per; i++) tick(i < high);
  endtask

  initial begin
    int s_hold, p_hold, per, high;
    // Reset state
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    cmp("rst_sample", sample0, 0);
    cmp("rst_valid", valid0, 0);
    cmp("rst_locked", locked0, 0);
    cmp("rst_perr", perr0, 0);
    rst = 1'b0;

    // Duty-128 frames: lock on the 4th strobe, sample 128
    repeat (6) frame(128, 256);
    cmp("lock_on_strobe", lock_strobe, 4);
    cmp("duty128_sample", sample0, 128);
    cmp("duty128_locked", locked0, 1);
    cmp("duty128_strobes", nstb0, 5);

    // Line low after lock: clean zero frames keep lock
    repeat (4) frame(0, 256);
    cmp("low_sample", sample0, 0);
    cmp("low_locked", locked0, 1);
    cmp("low_perr", perr0, 0);
    cmp("low_strobes", nstb0, 9);

    // Duty 255
    repeat (3) frame(255, 256);
    cmp("duty255_sample", sample0, 255);
    cmp("duty255_perr", perr0, 0);

    // Extra rise at frame position 100, then realigned frames
    frame(50, 100);
    frame(128, 256);
    cmp("perr_after_glitch", perr0, 1);
    cmp("unlock_after_glitch", locked0, 0);
    cmp("glitch_no_strobe", nstb0, 13);
    repeat (5) frame(128, 256);
    cmp("relock", locked0, 1);
    cmp("relock_perr", perr0, 1);

    // en dropped mid-frame: outputs cleared except sample and error count
    for (int i = 0; i < 60; i++) tick(i < 128);
    s_hold = sample0; p_hold = perr0;
    en = 1'b0;
    tick(1);
    cmp("en_valid", valid0, 0);
    cmp("en_locked", locked0, 0);
    cmp("en_sample_hold", sample0, s_hold);
    cmp("en_perr_hold", perr0, p_hold);
    en = 1'b1;
    for (int i = 61; i < 256; i++) tick(i < 128);

    // PW=9, 300 high of 512
    repeat (4) frame(300, 512);
    cmp("pw9_sample", sample1, 150);

    // rst pulsed mid-frame
    for (int i = 0; i < 100; i++) tick(i < 128);
    rst = 1'b1;
    tick(1);
    cmp("rst_mid_sample", sample0, 0);
    cmp("rst_mid_perr", perr0, 0);
    cmp("rst_mid_valid", valid0, 0);
    cmp("rst_mid_locked", locked0, 0);
    rst = 1'b0;
    for (int i = 101; i < 256; i++) tick(i < 128);

    // Randomized frames, occasional odd lengths and enable drops
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(99) < 75) begin
        per = 256; high = $urandom_range(256);
      end else begin
        per = $urandom_range(300, 20); high = $urandom_range(per);
      end
      if ($urandom_range(99) < 5) en = 1'b0;
      frame(high, per);
      en = 1'b1;
    end

    // Phase-error saturation
    repeat (310) frame(5, 10);
    cmp("perr_sat0", perr0, 255);
    cmp("perr_sat1", perr1, 255);

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_demod.md
PWM_DEMOD -- requirements
Module: pwm_demod

Interface
REQ-001 SHALL have parameter PW, default 8, meaning log2 of PWM frame length in clocks; legal range 8..12; PERIOD = 2^PW.
REQ-002 SHALL have parameter LOCK_FRAMES, default 4, meaning consecutive clean frames required to assert locked; legal range 1..15.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; every register is clocked on the rising edge.
REQ-004 SHALL have port rst, input, 1, meaning reset; synchronous and active-high.
REQ-005 SHALL have port en, input, 1, meaning receiver enable; low forces idle.
REQ-006 SHALL have port ain, input, 1, meaning PWM line, asynchronous to clk.
REQ-007 SHALL have port sample, output, 8, meaning the recovered duty-cycle value of the last completed frame.
REQ-008 SHALL have port sample_valid, output, 1, meaning a one-cycle strobe marking a new sample.
REQ-009 SHALL have port locked, output, 1, meaning frame phase is established and stable.
REQ-010 SHALL have port phase_err_cnt, output, 8, meaning a saturating count of phase errors.

Function
REQ-011 SHALL pass ain through a 2-flop synchronizer to produce s, then a third flop to produce s_d; rise = s & ~s_d.
REQ-012 SHALL implement FSM states HUNT and TRACK, with frame_cnt (PW bits) and high_cnt (PW+1 bits).
REQ-013 HUNT: frame_cnt and high_cnt SHALL hold 0; on rise, SHALL go to TRACK with frame_cnt=1 and high_cnt=1.
REQ-014 TRACK: each cycle, frame_cnt SHALL increment modulo PERIOD and high_cnt SHALL add s.
REQ-015 TRACK, cycle with frame_cnt==PERIOD-1 and no rise: frame end; next edge registers sample = min((high_cnt+s) >> (PW-8), 255); sample_valid=1; frame_cnt=0; high_cnt=0.
REQ-016 sample_valid SHALL be high for exactly one cycle per completed frame; sample SHALL hold between strobes.
REQ-017 A rise with frame_cnt==0 is the expected frame start; high_cnt counts it normally.
REQ-018 A rise with frame_cnt!=0 (including PERIOD-1) is a phase error. The in-progress frame SHALL be discarded (no strobe); frame_cnt=1 and high_cnt=1; phase_err_cnt SHALL increment, saturating at 255; the clean-frame counter SHALL clear; locked SHALL deassert.
REQ-019 Frames containing no rise (duty 0 or line stuck) are clean frames and SHALL emit a sample.
REQ-020 locked SHALL assert on the strobe cycle that completes the LOCK_FRAMES-th consecutive clean frame; the clean-frame counter SHALL saturate at LOCK_FRAMES.
REQ-021 en low SHALL, on the next edge, force HUNT, clear the counters, clear the clean-frame counter, and deassert locked and sample_valid. sample and phase_err_cnt SHALL hold. The synchronizer SHALL keep running.
REQ-022 Latency from the ain edge to the rise decision SHALL be 3 clocks; the strobe SHALL follow the last frame cycle by 1 clock.

Reset
REQ-023 rst high at a clock edge SHALL set sample=0, sample_valid=0, locked=0, phase_err_cnt=0, state=HUNT, all counters=0, and synchronizer flops=0.
REQ-024 rst SHALL take priority over en and over any in-progress frame; a frame interrupted by reset SHALL produce no strobe.

Verification
REQ-025 PW=8: reset, then continuous duty-128 frames (128 high / 128 low) -> strobe every 256 clocks with sample=128; locked rises on the 4th strobe.
REQ-026 After lock, 3 frames of line low -> 3 strobes with sample=0; locked stays 1; phase_err_cnt stays 0.
REQ-027 Duty-255 frames -> sample=255; PW=9 with 300 high of 512 -> sample=150.
REQ-028 After lock, an extra rise at frame_cnt=100 -> no strobe for that frame, locked=0, phase_err_cnt=1; frames then re-align to the new rise and locked returns after 4 clean frames.
REQ-029 rst pulsed mid-frame, or en dropped mid-frame -> next cycle shows HUNT, sample_valid=0, locked=0. For rst: sample=0 and phase_err_cnt=0. For en: sample and phase_err_cnt unchanged.
REQ-030 Inject 300 phase errors -> phase_err_cnt saturates at 255.
